// File: rtl/fifo_level_if.sv
// Handshake/status bundle for fifo_level: the producer/consumer side drives
// push/pop/wd, and the FIFO returns read data, level flags and error flags.
interface fifo_level_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             udf;

  modport master (
    output push, pop, wd,
    input  rd, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  push, pop, wd,
    output rd, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/fifo_level.sv
// Single-clock FIFO with occupancy counter, level flags and sticky error flags.
// FWFT selects a registered read port (0) or a first-word-fall-through read port (1).
module fifo_level #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  fifo_level_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic             ovf_q, udf_q;
  logic             full, empty;
  logic             do_push, do_pop;

  // Flags are decoded only from the registered count, so push/pop never
  // reach them combinationally.
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // A pop frees a slot in the same edge, so a push at full is accepted
  // when paired with a pop.
  assign do_push = bus.push & (~full | bus.pop);
  assign do_pop  = bus.pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.push & full & ~bus.pop) ovf_q <= 1'b1;
      if (bus.pop & empty)            udf_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset or flushed.
  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wp] <= bus.wd;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd = mem[rp];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_q <= '0;
        else if (clr)    rd_q <= '0;
        else if (do_pop) rd_q <= mem[rp];
      end
      assign bus.rd = rd_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= CW'(AF_THRESH));
  assign bus.almost_empty = (cnt <= CW'(AE_THRESH));
  assign bus.count        = cnt;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level: registered-read instance (a) and FWFT instance (b).
module tb_fifo_level;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  always #5 clk = ~clk;

  fifo_level_if #(.DEPTH(16), .WIDTH(8)) a ();
  fifo_level_if #(.DEPTH(16), .WIDTH(8)) b ();

  fifo_level #(.DEPTH(16), .WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
    dut_a (.clk(clk), .rst(rst), .clr(clr_a), .bus(a));
  fifo_level #(.DEPTH(16), .WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
    dut_b (.clk(clk), .rst(rst), .clr(clr_b), .bus(b));

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_rd  = 8'h00;
  logic [7:0] dat;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // {full, empty, almost_full, almost_empty, ovf, udf}
  function automatic logic [5:0] dut_flags();
    return {a.full, a.empty, a.almost_full, a.almost_empty, a.ovf, a.udf};
  endfunction

  function automatic logic [5:0] exp_flags();
    return {m_cnt == 16, m_cnt == 0, m_cnt >= 14, m_cnt <= 2, m_ovf, m_udf};
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".rd"},    int'(a.rd),    int'(m_rd));
    check({tag, ".count"}, int'(a.count), m_cnt);
    check({tag, ".flags"}, int'(dut_flags()), int'(exp_flags()));
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = 8'h00;
  endtask

  // One clock on instance a; caller is positioned 1ns after a rising edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    logic ap, aq;
    a.push = p; a.pop = q; a.wd = d;
    ap = p && (m_cnt < 16 || q);
    aq = q && (m_cnt > 0);
    if (p && !q && m_cnt == 16) m_ovf = 1'b1;
    if (q && m_cnt == 0)        m_udf = 1'b1;
    if (aq) m_rd = sb.pop_front();
    if (ap) sb.push_back(d);
    m_cnt = m_cnt + int'(ap) - int'(aq);
    @(posedge clk); #1;
    a.push = 1'b0; a.pop = 1'b0;
    check_state(p && q ? "pushpop" : (p ? "push" : (q ? "pop" : "idle")));
  endtask

  task automatic do_clr();
    clr_a = 1'b1; a.push = 1'b1; a.pop = 1'b1; a.wd = 8'hEE;
    @(posedge clk); #1;
    clr_a = 1'b0; a.push = 1'b0; a.pop = 1'b0;
    model_reset();
    check_state("clr");
  endtask

  initial begin
    a.push = 1'b0; a.pop = 1'b0; a.wd = 8'h00;
    b.push = 1'b0; b.pop = 1'b0; b.wd = 8'h00;

    // Reset state, observed before any clock edge
    #1 rst = 1'b1;
    #2;
    check_state("reset");
    check("b.reset.empty", int'(b.empty), 1);
    check("b.reset.count", int'(b.count), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Fill 0x00..0x0F, one push over the top, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    do_clr();

    // Simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 8'h55);
    while (m_cnt > 0) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h33);
    step(1'b0, 1'b1, 8'h00);
    do_clr();

    // Interleaved traffic across pointer wrap, occupancy kept in 3..10
    dat = 8'h80;
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0, dat); dat++; end
    for (int i = 0; i < 40; i++) begin
      if (m_cnt >= 10)     step(1'b0, 1'b1, 8'h00);
      else if (m_cnt <= 3) begin step(1'b1, 1'b0, dat); dat++; end
      else begin
        case ($urandom_range(0, 2))
          0:       begin step(1'b1, 1'b0, dat); dat++; end
          1:       step(1'b0, 1'b1, 8'h00);
          default: begin step(1'b1, 1'b1, dat); dat++; end
        endcase
      end
    end
    while (m_cnt > 0) step(1'b0, 1'b1, 8'h00);

    // Async reset pulse between edges at count 9
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    check_state("async_rst");
    step(1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b1, 8'h00);

    // FWFT instance
    b.push = 1'b1; b.wd = 8'h7E;
    @(posedge clk); #1 b.push = 1'b0;
    check("b.fwft.empty", int'(b.empty), 0);
    check("b.fwft.rd",    int'(b.rd),    8'h7E);
    check("b.fwft.count", int'(b.count), 1);
    b.pop = 1'b1;
    @(posedge clk); #1 b.pop = 1'b0;
    check("b.pop.empty", int'(b.empty), 1);
    check("b.pop.count", int'(b.count), 0);
    b.push = 1'b1; b.wd = 8'h11;
    @(posedge clk); #1 b.wd = 8'h22;
    @(posedge clk); #1 b.push = 1'b0;
    check("b.head0", int'(b.rd), 8'h11);
    b.pop = 1'b1;
    @(posedge clk); #1 b.pop = 1'b0;
    check("b.head1", int'(b.rd),    8'h22);
    check("b.count", int'(b.count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
